// File: rtl/bn_pkg.sv
// ---------------------------------------------------------------------------
// bn_pkg
// Shared types and default sizing for the batch-norm + activation pipeline.
//   act_mode_e  : activation selector carried with every beat
//   DEF_*       : default parameter values used by the top and lane modules
//   PROD_W      : width of the signed x*A product for the default sizing
//   RELU6_MAX   : value 6.0 in the x/y fixed-point format (default sizing)
// ---------------------------------------------------------------------------
package bn_pkg;

  // Code 3 is reserved and deliberately absent; it falls into the
  // "no activation" branch wherever the mode is decoded.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2
  } act_mode_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_X_FRAC    = 8;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_A_FRAC    = 8;
  localparam int DEF_N         = 4;
  localparam int DEF_GRP_DEPTH = 16;
  localparam int DEF_CNT_W     = 16;

  localparam int PROD_W = DEF_DATA_W + DEF_COEF_W;

  // 6.0 expressed with x_frac fraction bits
  function automatic int relu6_max(input int x_frac);
    return 6 << x_frac;
  endfunction

  localparam int RELU6_MAX = relu6_max(DEF_X_FRAC);

endpackage

// File: rtl/bn_lane.sv
// ---------------------------------------------------------------------------
// bn_lane
// One lane of the three-stage batch-norm datapath: y = sat(act(round(x*A + B))).
//   clk, rst_n      : clock, asynchronous active-low reset
//   en1, en2, en3   : load enables for stage 1/2/3 registers (from the top)
//   x, a, b, mode   : beat inputs captured into stage 1
//   y, sat          : stage-3 result and final-clamp flag
// Stage 1 holds the raw product, stage 2 the rounded sum, stage 3 the
// activated and saturated result.
// ---------------------------------------------------------------------------
module bn_lane
  import bn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int A_FRAC = DEF_A_FRAC,
  parameter int P_W    = PROD_W,
  parameter int R6_MAX = RELU6_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en1,
  input  logic                     en2,
  input  logic                     en3,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [1:0]               mode,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  // One guard bit above the product so adding B and the rounding half
  // can never overflow the sum.
  localparam int S_W = P_W + 1;

  localparam logic signed [S_W-1:0] HALF    = S_W'(1) << (A_FRAC - 1);
  localparam logic signed [S_W-1:0] RELU6_C = S_W'(R6_MAX);
  localparam logic signed [S_W-1:0] Y_MAX   = {{(S_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] Y_MIN   = {{(S_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [P_W-1:0]    x_ext;
  logic signed [P_W-1:0]    a_ext;
  logic signed [P_W-1:0]    prod_c;
  logic signed [P_W-1:0]    p1;
  logic signed [DATA_W-1:0] b1;
  logic [1:0]               mode1;

  logic signed [S_W-1:0]    b_ext;
  logic signed [S_W-1:0]    sum_c;
  logic signed [S_W-1:0]    r_c;
  logic signed [S_W-1:0]    r2;
  logic [1:0]               mode2;

  logic signed [S_W-1:0]    act_c;
  logic signed [DATA_W-1:0] y_c;
  logic                     sat_c;

  // Both operands are sign-extended to the full product width so the
  // truncated product equals the exact signed product.
  assign x_ext  = P_W'(x);
  assign a_ext  = P_W'(a);
  assign prod_c = x_ext * a_ext;

  // Stage 1: product plus the bias and mode that travel with this beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1    <= '0;
      b1    <= '0;
      mode1 <= '0;
    end else if (en1) begin
      p1    <= prod_c;
      b1    <= b;
      mode1 <= mode;
    end
  end

  // B is aligned to the product's A_FRAC+X_FRAC scale; adding half an LSB
  // before the arithmetic shift rounds half-up (toward +infinity on ties).
  assign b_ext = S_W'(b1) <<< A_FRAC;
  assign sum_c = S_W'(p1) + b_ext + HALF;
  assign r_c   = sum_c >>> A_FRAC;

  // Stage 2: rounded value back in x/y fixed-point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2    <= '0;
      mode2 <= '0;
    end else if (en2) begin
      r2    <= r_c;
      mode2 <= mode1;
    end
  end

  // Activation first, then the output clamp. Only the clamp raises the
  // saturation flag; ReLU/ReLU6 clipping is ordinary behaviour.
  always_comb begin
    act_c = r2;
    case (mode2)
      ACT_RELU: begin
        if (r2 < 0) act_c = '0;
      end
      ACT_RELU6: begin
        if (r2 < 0)             act_c = '0;
        else if (r2 > RELU6_C)  act_c = RELU6_C;
      end
      default: ;
    endcase

    sat_c = 1'b0;
    y_c   = act_c[DATA_W-1:0];
    if (act_c > Y_MAX) begin
      y_c   = Y_MAX[DATA_W-1:0];
      sat_c = 1'b1;
    end else if (act_c < Y_MIN) begin
      y_c   = Y_MIN[DATA_W-1:0];
      sat_c = 1'b1;
    end
  end

  // Stage 3: output register; only reloads when the beat moves on, so the
  // presented result is stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en3) begin
      y   <= y_c;
      sat <= sat_c;
    end
  end

endmodule

// File: rtl/batch_norm_act_pipe.sv
// ---------------------------------------------------------------------------
// batch_norm_act_pipe
// Streaming per-channel batch-norm (y = A*x + B) with optional ReLU/ReLU6,
// rounding and saturation over N lanes, 3-stage valid/ready pipeline.
//   CLK, RST             : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_row, in_grp       : N signed lanes, coefficient set selector
//   in_mode              : 0 none, 1 ReLU, 2 ReLU6, 3 treated as none
//   out_valid/out_ready  : output handshake, out_row result lanes
//   cfg_we/cfg_addr      : write strobe and set address for the bank
//   cfg_a, cfg_b         : A and B lanes for the set being written
//   sat_count, sat_clr   : sticky count of beats with a clamped lane, clear
// ---------------------------------------------------------------------------
module batch_norm_act_pipe
  import bn_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int X_FRAC    = DEF_X_FRAC,
  parameter  int COEF_W    = DEF_COEF_W,
  parameter  int A_FRAC    = DEF_A_FRAC,
  parameter  int N         = DEF_N,
  parameter  int GRP_DEPTH = DEF_GRP_DEPTH,
  parameter  int CNT_W     = DEF_CNT_W,
  localparam int GRP_AW    = (GRP_DEPTH > 1) ? $clog2(GRP_DEPTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_row,
  input  logic [GRP_AW-1:0]     in_grp,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DATA_W-1:0]   out_row,
  input  logic                  cfg_we,
  input  logic [GRP_AW-1:0]     cfg_addr,
  input  logic [N*COEF_W-1:0]   cfg_a,
  input  logic [N*DATA_W-1:0]   cfg_b,
  output logic [CNT_W-1:0]      sat_count,
  input  logic                  sat_clr
);

  localparam logic [COEF_W-1:0]   A_ONE    = COEF_W'(1) << A_FRAC;
  localparam logic [N*COEF_W-1:0] A_ID_ROW = {N{A_ONE}};
  localparam logic [GRP_AW:0]     DEPTH_C  = (GRP_AW+1)'(GRP_DEPTH);

  logic v1, v2, v3;
  logic ready1, ready2, ready3;
  logic en1, en2, en3;

  logic [N*COEF_W-1:0] bank_a [GRP_DEPTH];
  logic [N*DATA_W-1:0] bank_b [GRP_DEPTH];
  logic                grp_ok;
  logic [N*COEF_W-1:0] rd_a;
  logic [N*DATA_W-1:0] rd_b;

  logic [N-1:0] lane_sat;
  logic         any_sat;

  // A stage may load when it is empty or its occupant leaves this cycle;
  // the readiness chain runs backward from the output.
  assign ready3 = !v3 || out_ready;
  assign ready2 = !v2 || ready3;
  assign ready1 = !v1 || ready2;

  assign en1 = in_valid && ready1;
  assign en2 = v1 && ready2;
  assign en3 = v2 && ready3;

  assign in_ready  = ready1;
  assign out_valid = v3;

  // Stage valid bits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ready1) v1 <= in_valid;
      if (ready2) v2 <= v1;
      if (ready3) v3 <= v2;
    end
  end

  // Coefficient bank: every set resets to identity. A write lands on the
  // clock edge, so a beat accepted on that same edge still sees the old set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int g = 0; g < GRP_DEPTH; g++) begin
        bank_a[g] <= A_ID_ROW;
        bank_b[g] <= '0;
      end
    end else if (cfg_we) begin
      bank_a[cfg_addr] <= cfg_a;
      bank_b[cfg_addr] <= cfg_b;
    end
  end

  // Out-of-range groups (only possible for non power-of-two depths) fall
  // back to identity so the read never indexes past the array.
  assign grp_ok = ({1'b0, in_grp} < DEPTH_C);
  assign rd_a   = grp_ok ? bank_a[in_grp] : A_ID_ROW;
  assign rd_b   = grp_ok ? bank_b[in_grp] : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    bn_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .A_FRAC (A_FRAC),
      .P_W    (DATA_W + COEF_W),
      .R6_MAX (relu6_max(X_FRAC))
    ) u_lane (
      .clk   (CLK),
      .rst_n (RST),
      .en1   (en1),
      .en2   (en2),
      .en3   (en3),
      .x     (in_row[i*DATA_W +: DATA_W]),
      .a     (rd_a[i*COEF_W +: COEF_W]),
      .b     (rd_b[i*DATA_W +: DATA_W]),
      .mode  (in_mode),
      .y     (out_row[i*DATA_W +: DATA_W]),
      .sat   (lane_sat[i])
    );
  end

  assign any_sat = |lane_sat;

  // Saturation counter: counts beats as they leave, sticks at all-ones,
  // and a clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (v3 && out_ready && any_sat && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule
